// File: rtl/ts_trans_pkg.sv
// Shared definitions for the transform-datapath arbiter: FSM state encoding
// and default timing limits.
package ts_trans_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOP = 2'd1,
    ST_XFER     = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  localparam int DATA_W          = 32;
  localparam int GAP_CYCLES_DEF  = 2;
  localparam int SOP_TIMEOUT_DEF = 16;
  localparam int MAX_WORDS_DEF   = 376;

endpackage

// File: rtl/ts_trans_arbiter_rr_pick.sv
// Rotating priority encoder: first requesting channel strictly after rr_ptr,
// wrapping around, so the last served channel has the lowest priority.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req_vec,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [CH_W-1:0]   winner,
  output logic              valid
);

  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic [CH_W:0] cand;

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    winner = '0;
    valid  = |req_vec;
    cand   = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (cand >= NUM_CH_L) cand = cand - NUM_CH_L;
      if (req_vec[cand[CH_W-1:0]]) winner = cand[CH_W-1:0];
    end
  end

endmodule

// File: rtl/ts_trans_arbiter.sv
// Packet-level round-robin arbiter feeding one shared 32-bit transform stream,
// with SOP timeout, length truncation and a guaranteed inter-packet idle gap.
module ts_trans_arbiter
  import ts_trans_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = $clog2(NUM_CH),
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int SOP_TIMEOUT = SOP_TIMEOUT_DEF,
  parameter int MAX_WORDS   = MAX_WORDS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_vec,
  input  logic [NUM_CH*DATA_W-1:0] ch_din,
  input  logic [NUM_CH-1:0]        ch_din_en,
  input  logic                     downstream_ready,
  output logic [NUM_CH-1:0]        grant_vec,
  output logic [CH_W-1:0]          cur_ch,
  output logic [DATA_W-1:0]        dout_32bit,
  output logic                     dout_32bit_en,
  output logic                     busy,
  output logic                     timeout_pulse,
  output logic                     trunc_pulse
);

  localparam int TMR_W = $clog2(SOP_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int WC_W  = $clog2(MAX_WORDS + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SOP_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(MAX_WORDS);

  state_t              state, state_nxt;
  logic [CH_W-1:0]     rr_ptr, rr_ptr_nxt, cur_ch_nxt;
  logic [NUM_CH-1:0]   grant_nxt;
  logic [TMR_W-1:0]    timer, timer_nxt;
  logic [GAP_W-1:0]    gap_cnt, gap_nxt;
  logic [WC_W-1:0]     word_cnt, word_nxt;
  logic                tmo_nxt, trunc_nxt;

  logic [CH_W-1:0]     pick_winner;
  logic                pick_valid;

  logic [DATA_W-1:0]   ch_word [NUM_CH];
  logic [DATA_W-1:0]   sel_word;
  logic                sel_en, sel_req;

  logic                vld_p0;
  logic [DATA_W-1:0]   dout_p1;
  logic                vld_p1;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_word[k] = ch_din[k*DATA_W +: DATA_W];
  end

  assign sel_word = ch_word[cur_ch];
  assign sel_en   = ch_din_en[cur_ch];
  assign sel_req  = req_vec[cur_ch];

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .req_vec (req_vec),
    .rr_ptr  (rr_ptr),
    .winner  (pick_winner),
    .valid   (pick_valid)
  );

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    cur_ch_nxt = cur_ch;
    grant_nxt  = grant_vec;
    timer_nxt  = timer;
    gap_nxt    = gap_cnt;
    word_nxt   = word_cnt;
    tmo_nxt    = 1'b0;
    trunc_nxt  = 1'b0;
    vld_p0     = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_nxt = '0;
        if (downstream_ready && pick_valid) begin
          state_nxt              = ST_WAIT_SOP;
          rr_ptr_nxt             = pick_winner;
          cur_ch_nxt             = pick_winner;
          grant_nxt[pick_winner] = 1'b1;
          timer_nxt              = '0;
        end
      end
      ST_WAIT_SOP: begin
        // A first word arriving on the timeout cycle still starts the packet.
        if (sel_en) begin
          state_nxt = ST_XFER;
          vld_p0    = 1'b1;
          word_nxt  = WC_W'(1);
        end else if (!sel_req) begin
          state_nxt = ST_GAP;
          grant_nxt = '0;
          gap_nxt   = '0;
        end else if (timer == TMR_LAST) begin
          state_nxt = ST_GAP;
          grant_nxt = '0;
          gap_nxt   = '0;
          tmo_nxt   = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ST_XFER: begin
        if (!sel_en) begin
          state_nxt = ST_GAP;
          grant_nxt = '0;
          gap_nxt   = '0;
        end else if (word_cnt == WC_MAX) begin
          state_nxt = ST_GAP;
          grant_nxt = '0;
          gap_nxt   = '0;
          trunc_nxt = 1'b1;
        end else begin
          vld_p0   = 1'b1;
          word_nxt = word_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        grant_nxt = '0;
        if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
        else                     gap_nxt   = gap_cnt + 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= CH_W'(NUM_CH - 1);
      cur_ch        <= '0;
      grant_vec     <= '0;
      timer         <= '0;
      gap_cnt       <= '0;
      word_cnt      <= '0;
      timeout_pulse <= 1'b0;
      trunc_pulse   <= 1'b0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_ptr_nxt;
      cur_ch        <= cur_ch_nxt;
      grant_vec     <= grant_nxt;
      timer         <= timer_nxt;
      gap_cnt       <= gap_nxt;
      word_cnt      <= word_nxt;
      timeout_pulse <= tmo_nxt;
      trunc_pulse   <= trunc_nxt;
    end
  end

  // Stage p0 -> p1: forwarded word and frame enable, one cycle of latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) dout_p1 <= sel_word;
    end
  end

  assign dout_32bit    = dout_p1;
  assign dout_32bit_en = vld_p1;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_ts_trans_arbiter.sv
// Directed and randomized bench for ts_trans_arbiter: a packet-level model
// predicts winners, forwarded words, pulses and gap timing.
module tb_ts_trans_arbiter;

  localparam int NUM_CH      = 4;
  localparam int CH_W        = 2;
  localparam int GAP_CYCLES  = 2;
  localparam int SOP_TIMEOUT = 16;
  localparam int MAX_WORDS   = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_CH-1:0]      req_vec;
  logic [NUM_CH*32-1:0]   ch_din;
  logic [NUM_CH-1:0]      ch_din_en;
  logic                   downstream_ready;
  logic [NUM_CH-1:0]      grant_vec;
  logic [CH_W-1:0]        cur_ch;
  logic [31:0]            dout_32bit;
  logic                   dout_32bit_en;
  logic                   busy;
  logic                   timeout_pulse;
  logic                   trunc_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  int          model_ptr = NUM_CH - 1;
  logic [39:0] exp_q [$];
  bit          score_on = 1'b1;
  int          exp_tmo = 0, exp_trunc = 0;
  int          tmo_seen = 0, trunc_seen = 0;
  int          since_word = 1000;
  logic [31:0] last_word = '0;
  logic [NUM_CH-1:0] prev_grant = '0;

  always #5 clk = ~clk;

  ts_trans_arbiter #(
    .NUM_CH      (NUM_CH),
    .CH_W        (CH_W),
    .GAP_CYCLES  (GAP_CYCLES),
    .SOP_TIMEOUT (SOP_TIMEOUT),
    .MAX_WORDS   (MAX_WORDS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_vec          (req_vec),
    .ch_din           (ch_din),
    .ch_din_en        (ch_din_en),
    .downstream_ready (downstream_ready),
    .grant_vec        (grant_vec),
    .cur_ch           (cur_ch),
    .dout_32bit       (dout_32bit),
    .dout_32bit_en    (dout_32bit_en),
    .busy             (busy),
    .timeout_pulse    (timeout_pulse),
    .trunc_pulse      (trunc_pulse)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester strictly after the last served channel.
  function automatic int model_pick();
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (model_ptr + k) % NUM_CH;
      if (req_vec[c]) return c;
    end
    return 0;
  endfunction

  task automatic monitor();
    logic [39:0] e;
    if (rst) begin
      since_word = 1000;
      last_word  = '0;
      prev_grant = '0;
      return;
    end
    check("grant_onehot0", $onehot0(grant_vec), 1);
    if (timeout_pulse) tmo_seen++;
    if (trunc_pulse) trunc_seen++;
    if (prev_grant == '0 && grant_vec != '0)
      check("grant_spacing", since_word >= GAP_CYCLES + 1, 1);
    if (dout_32bit_en) begin
      if (since_word > 0 && since_word < 1000)
        check("idle_gap", since_word >= GAP_CYCLES, 1);
      if (score_on) begin
        check("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("word", dout_32bit, e[31:0]);
          check("word_ch", cur_ch, e[39:32]);
        end
      end
      last_word  = dout_32bit;
      since_word = 0;
    end else begin
      check("dout_hold", dout_32bit, last_word);
      if (since_word < 1000) since_word++;
    end
    prev_grant = grant_vec;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic take_grant(output int exp_c, output int obs_c);
    int waited;
    exp_c  = model_pick();
    waited = 0;
    while (grant_vec == '0 && waited < 200) begin
      step();
      waited++;
    end
    check("grant_arrives", waited < 200, 1);
    check("grant_vec", grant_vec, NUM_CH'(1) << exp_c);
    check("cur_ch", cur_ch, exp_c);
    model_ptr = exp_c;
    obs_c     = int'(cur_ch);
  endtask

  task automatic serve(input int len, input int dly, input bit drop_req, output int obs_c);
    int          c;
    logic [31:0] w32;
    logic        tp;
    take_grant(c, obs_c);
    repeat (dly) step();
    tp = 1'b0;
    for (int w = 0; w < len; w++) begin
      if (grant_vec[c] !== 1'b1) break;
      w32 = $urandom();
      ch_din[32*c +: 32] = w32;
      ch_din_en[c] = 1'b1;
      if (w < MAX_WORDS) exp_q.push_back({c[7:0], w32});
      step();
      tp = trunc_pulse;
    end
    ch_din_en[c] = 1'b0;
    if (drop_req) req_vec[c] = 1'b0;
    if (len > MAX_WORDS) exp_trunc++;
    check("trunc_pulse", tp, len > MAX_WORDS);
    step();
    check("grant_released", grant_vec, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int oc, ec, held, guard;
    rst = 1'b1;
    req_vec = '0;
    ch_din = '0;
    ch_din_en = '0;
    downstream_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant_vec, '0);
    check("rst_cur_ch", cur_ch, 0);
    check("rst_dout", dout_32bit, 0);
    check("rst_en", dout_32bit_en, 0);
    check("rst_busy", busy, 0);
    check("rst_tmo", timeout_pulse, 0);
    check("rst_trunc", trunc_pulse, 0);
    rst = 1'b0;
    step();

    // Round-robin with every channel requesting continuously
    req_vec = '1;
    for (int i = 0; i < 5; i++) begin
      serve(3, int'($urandom_range(0, 2)), 1'b0, oc);
      check("rr_order", oc, i % NUM_CH);
    end
    req_vec = '0;
    repeat (4) step();

    // Single channel, four words starting two cycles after grant
    req_vec = 4'b0001;
    serve(4, 2, 1'b1, oc);
    check("single_ch", oc, 0);
    check("single_busy_gap0", busy, 1);
    step();
    check("single_busy_gap1", busy, 1);
    check("single_en_low", dout_32bit_en, 0);
    step();
    check("single_busy_fall", busy, 0);

    // Back-pressure holds off the grant
    downstream_ready = 1'b0;
    req_vec = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_no_grant", grant_vec, '0);
    end
    downstream_ready = 1'b1;
    step();
    check("bp_grant", grant_vec, 4'b0010);
    serve(3, 1, 1'b1, oc);
    repeat (3) step();

    // SOP timeout on ch2, ch3 next despite ch2 still requesting
    req_vec = 4'b0100;
    take_grant(ec, oc);
    held = 0;
    while (grant_vec[2] === 1'b1 && held < 40) begin
      check("no_early_timeout", timeout_pulse, 0);
      step();
      held++;
    end
    check("grant_hold_cycles", held, SOP_TIMEOUT);
    check("timeout_pulse", timeout_pulse, 1);
    exp_tmo++;
    req_vec[3] = 1'b1;
    step();
    check("timeout_single_cycle", timeout_pulse, 0);
    serve(3, 0, 1'b1, oc);
    check("after_timeout_ch", oc, 3);
    serve(2, 1, 1'b1, oc);
    repeat (3) step();

    // Source withdraws before its first word
    req_vec = 4'b0001;
    take_grant(ec, oc);
    repeat (3) step();
    req_vec[0] = 1'b0;
    step();
    check("withdraw_grant", grant_vec, '0);
    check("withdraw_busy", busy, 1);
    check("withdraw_no_pulse", timeout_pulse, 0);
    repeat (3) step();
    check("withdraw_idle", busy, 0);

    // Over-length packet is truncated at MAX_WORDS
    req_vec = 4'b0010;
    serve(12, 1, 1'b1, oc);
    check("trunc_ch", oc, 1);
    repeat (3) step();

    // Randomized request sets, lengths and start delays
    for (int r = 0; r < 10; r++) begin
      req_vec = NUM_CH'($urandom_range(1, 15));
      guard = 0;
      while (req_vec != '0 && guard < 8) begin
        serve(int'($urandom_range(1, 12)), int'($urandom_range(0, 4)), 1'b1, oc);
        guard++;
      end
      repeat (int'($urandom_range(0, 3))) step();
    end
    repeat (5) step();
    check("scoreboard_drained", exp_q.size(), 0);
    check("timeout_count", tmo_seen, exp_tmo);
    check("trunc_count", trunc_seen, exp_trunc);

    // Asynchronous reset during the third word of a packet
    score_on = 1'b0;
    req_vec = 4'b0100;
    take_grant(ec, oc);
    for (int w = 0; w < 3; w++) begin
      ch_din[64 +: 32] = $urandom();
      ch_din_en[2] = 1'b1;
      step();
    end
    check("rst_mid_en_before", dout_32bit_en, 1);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_en", dout_32bit_en, 0);
    check("rst_mid_grant", grant_vec, '0);
    check("rst_mid_busy", busy, 0);
    ch_din_en = '0;
    req_vec = '0;
    step();
    step();
    rst = 1'b0;
    model_ptr = NUM_CH - 1;
    score_on = 1'b1;
    req_vec = '1;
    take_grant(ec, oc);
    check("rst_first_grant", oc, 0);
    req_vec = '0;
    repeat (4) step();
    check("rst_end_idle", busy, 0);
    check("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
